// File: rtl/voice_mixer_48.sv
// voice_mixer_48
//   Time-multiplexed 48-voice sawtooth mixer. Each one-hot event slot advances
//   one voice's phase accumulator and adds its velocity-scaled sample into a
//   frame sum. After slot 47 the sum is scaled, saturated and emitted as one
//   signed sample per frame.
//
// Ports
//   clk           system clock
//   rst           synchronous active-high reset
//   events        one-hot slot strobes, bit k high for one cycle in slot k
//   cfg_we        config write strobe
//   cfg_voice     voice index to write (48..63 ignored)
//   cfg_inc       phase increment per frame
//   cfg_vel       velocity (unsigned)
//   cfg_gate      1 = note on, 0 = note off
//   sample_out    signed mixed sample, held between strobes
//   sample_valid  one-cycle strobe per frame, 3 cycles after events[47]

module voice_mixer_48 #(
    parameter int NVOICE   = 48,
    parameter int PHASE_W  = 24,
    parameter int VEL_W    = 7,
    parameter int SAMPLE_W = 16,
    parameter int ACC_W    = 21
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NVOICE-1:0]          events,
    input  logic                       cfg_we,
    input  logic [5:0]                 cfg_voice,
    input  logic [PHASE_W-1:0]         cfg_inc,
    input  logic [VEL_W-1:0]           cfg_vel,
    input  logic                       cfg_gate,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       sample_valid
);

    localparam int PROD_W = VEL_W + 8;
    localparam logic [5:0] NV6   = 6'(NVOICE);
    localparam logic [5:0] LAST6 = 6'(NVOICE - 1);
    localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((2 ** (SAMPLE_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

    logic [NVOICE-1:0][PHASE_W-1:0] phase;
    logic [NVOICE-1:0][PHASE_W-1:0] inc;
    logic [NVOICE-1:0][VEL_W-1:0]   vel;
    logic [NVOICE-1:0]              gate;

    logic                      ev_any;
    logic [5:0]                ev_idx;
    logic                      vld1;
    logic [5:0]                idx1;
    logic                      vld2;
    logic                      last2;
    logic signed [PROD_W-1:0]  p2;
    logic signed [ACC_W-1:0]   acc;

    logic [PHASE_W-1:0]        rd_phase;
    logic [PHASE_W-1:0]        rd_inc;
    logic [VEL_W-1:0]          rd_vel;
    logic                      rd_gate;
    logic signed [7:0]         saw;
    logic signed [PROD_W-1:0]  saw_x;
    logic signed [PROD_W-1:0]  vel_x;
    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W-1:0]   sum;
    logic signed [ACC_W-1:0]   shifted;
    logic signed [SAMPLE_W-1:0] sat_val;
    logic                      cfg_hit;

    // Lowest set bit wins when more than one strobe is high.
    always_comb begin
        ev_any = |events;
        ev_idx = '0;
        for (int k = NVOICE - 1; k >= 0; k--) begin
            if (events[k]) ev_idx = 6'(k);
        end
    end

    always_comb begin
        rd_phase = phase[idx1];
        rd_inc   = inc[idx1];
        rd_vel   = vel[idx1];
        rd_gate  = gate[idx1];
        // Top phase byte with MSB flipped gives a signed sawtooth centred on 0.
        saw      = {~rd_phase[PHASE_W-1], rd_phase[PHASE_W-2:PHASE_W-8]};
        saw_x    = {{(PROD_W - 8){saw[7]}}, saw};
        vel_x    = {{(PROD_W - VEL_W){1'b0}}, rd_vel};
        prod     = saw_x * vel_x;
        sum      = acc + {{(ACC_W - PROD_W){p2[PROD_W-1]}}, p2};
        shifted  = sum >>> 4;
        if (shifted > SMAX)
            sat_val = {1'b0, {(SAMPLE_W - 1){1'b1}}};
        else if (shifted < SMIN)
            sat_val = {1'b1, {(SAMPLE_W - 1){1'b0}}};
        else
            sat_val = shifted[SAMPLE_W-1:0];
        cfg_hit  = cfg_we && (cfg_voice < NV6);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase        <= '0;
            inc          <= '0;
            vel          <= '0;
            gate         <= '0;
            vld1         <= 1'b0;
            idx1         <= '0;
            vld2         <= 1'b0;
            last2        <= 1'b0;
            p2           <= '0;
            acc          <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            vld1  <= ev_any;
            idx1  <= ev_idx;
            vld2  <= vld1;
            last2 <= (idx1 == LAST6);
            p2    <= (vld1 && rd_gate) ? prod : '0;

            // Phase keeps running while the gate is off.
            if (vld1) phase[idx1] <= rd_phase + rd_inc;

            // Placed after the phase update so a retrigger on the same voice wins.
            if (cfg_hit) begin
                inc[cfg_voice]  <= cfg_inc;
                vel[cfg_voice]  <= cfg_vel;
                gate[cfg_voice] <= cfg_gate;
                if (cfg_gate && !gate[cfg_voice]) phase[cfg_voice] <= '0;
            end

            sample_valid <= 1'b0;
            if (vld2) begin
                if (last2) begin
                    sample_out   <= sat_val;
                    acc          <= '0;
                    sample_valid <= 1'b1;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

endmodule

// File: doc/voice_mixer_48.md
Name: voice_mixer_48

Overview:
- Downstream consumer of the 48-slot one-hot event strobe generator (48 slots per 667-cycle frame, ≈48 kHz frame rate).
- Time-multiplexes 48 sawtooth voices: each event slot advances one voice's phase accumulator and adds its velocity-scaled sample into a frame sum.
- After slot 47, emits one saturated signed audio sample per frame toward the DAC/output stage.
- Per-voice pitch, velocity and gate are written by the upstream MIDI note decoder over a simple write port.

Parameters:
- NVOICE, 48, number of voices; equals the event vector width.
- PHASE_W, 24, phase accumulator and phase increment width.
- VEL_W, 7, velocity width (unsigned, MIDI range).
- SAMPLE_W, 16, output sample width (signed).
- ACC_W, 21, frame accumulator width (signed).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- events  in  48  one-hot slot strobes; bit k is high for one cycle in slot k.
- cfg_we  in  1  config write strobe.
- cfg_voice  in  6  voice index to write; values 48..63 are ignored.
- cfg_inc  in  24  phase increment per frame.
- cfg_vel  in  7  velocity.
- cfg_gate  in  1  1 = note on, 0 = note off.
- sample_out  out  16  signed mixed sample.
- sample_valid  out  1  one-cycle strobe, once per frame.

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high.

Reset:
- Clears phase, inc, vel and gate for all 48 voices.
- Clears the accumulator and all pipeline valid flags.
- sample_out = 0, sample_valid = 0.
- Reset mid-frame discards the partial sum. The next sample contains only voices processed after reset release.

Event decode:
- Zero bits set: no action.
- More than one bit set (illegal input): the lowest set index is used.

Pipeline (t = cycle in which events[k] is high):
- Edge E1 (end of t): register vld1 and idx1 = k.
- Edge E2 (end of t+1):
  - Read phase/inc/vel/gate[idx1] as held during cycle t+1.
  - phase[idx1] <= phase + inc, modulo 2^24.
  - saw = phase_old[23:16] XOR 0x80, interpreted as signed 8-bit.
  - p2 = saw * vel as a signed 15-bit product if gate = 1, else 0.
  - Register vld2 and last2 = (idx1 == 47).
  - The phase advances even when the gate is off.
- Edge E3 (end of t+2), when vld2:
  - If last2: sample_out <= sat16((acc + p2) >>> 4), acc <= 0, sample_valid <= 1.
  - Otherwise: acc <= acc + p2.
  - sample_valid is high during cycle t+3 and 0 on every other cycle.
- Latency: events[47] to sample_valid is 3 cycles. sample_out holds its value between strobes.

Arithmetic:
- Maximum |sum| is 48 * 16384 = 786432 < 2^20, so the 21-bit accumulator never overflows.
- >>> is an arithmetic (flooring) shift.
- sat16 clamps the result to [-32768, 32767].

Config writes:
- Take effect at the clock edge. An E2 read in the same cycle uses the pre-write values.
- Retrigger: a write with cfg_gate = 1 to a voice whose gate is 0 also sets its phase to 0.
- If a retrigger coincides with the E2 phase update for the same voice, the retrigger wins (phase = 0). Otherwise the E2 update wins the phase register, and the write still updates inc/vel/gate.

Test Plan:
- Timing/idle: reset, no config, run 3 frames. sample_valid pulses exactly once per 667 cycles, 3 cycles after events[47]; sample_out = 0.
- Static voice: voice 0 gate = 1, vel = 127, inc = 0. saw = -128, p = -16256. Every frame sample_out = -1016 (0xFC08).
- Ramp: voice 5 gate = 1, vel = 64, inc = 0x010000.
  - Frame n gives sample_out = (n - 128) * 4: frame 0 = -512, frame 1 = -508, frame 255 = 508.
  - Frame 256 wraps back to -512.
- Saturation: all 48 voices gate = 1, vel = 127, inc = 0. Sum -780288 >>> 4 = -48768, so sample_out = -32768 (0x8000).
- Config edge cases:
  - Retrigger voice 5 (gate 0 then 1) mid-ramp: phase restarts, next sample = -512.
  - Write to cfg_voice = 50: no state change.
  - Write to voice 3 in the same cycle as its E2: old vel used this frame, new vel used next frame.
- Reset mid-frame: voices 0..47 static as in the saturation test; assert rst for 1 cycle right after events[20].
  - sample_out and sample_valid read 0 after reset.
  - State is cleared, so no voice is active and the next sample is 0.
  - Reconfigure voice 30 during the same frame (vel = 127, gate = 1, inc = 0): next sample = -1016.
